// File: rtl/gan_pkg.sv
// Shared GAN front-end types and fixed-point constants.
// Holds the default frame geometry, the Q8.8 format and the loader FSM states.
package gan_pkg;

    localparam int PIXEL_COUNT = 784;
    localparam int Q_DATA_W    = 16;
    localparam int Q_FRAC_BITS = 8;

    localparam logic [Q_DATA_W-1:0] Q_ONE = 16'h0100;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } loader_state_t;

endpackage

// File: rtl/pixel_frame_loader_if.sv
// Bit-stream and frame bundle between the serial source and the pixel loader.
// master: source/downstream side; slave: the loader itself.
interface pixel_frame_loader_if #(
    parameter int PIXEL_COUNT = gan_pkg::PIXEL_COUNT,
    parameter int DATA_W      = gan_pkg::Q_DATA_W
);

    localparam int CNT_W = $clog2(PIXEL_COUNT + 1);

    logic                          pixel_bit;
    logic                          pixel_bit_valid;
    logic                          pixel_bit_ready;
    logic                          gray_mode;
    logic                          frame_abort;
    logic                          frame_consume;
    logic                          frame_ready;
    logic [DATA_W*PIXEL_COUNT-1:0] frame_flat;
    logic [CNT_W-1:0]              pixels_loaded;

    modport master (
        output pixel_bit,
        output pixel_bit_valid,
        output gray_mode,
        output frame_abort,
        output frame_consume,
        input  pixel_bit_ready,
        input  frame_ready,
        input  frame_flat,
        input  pixels_loaded
    );

    modport slave (
        input  pixel_bit,
        input  pixel_bit_valid,
        input  gray_mode,
        input  frame_abort,
        input  frame_consume,
        output pixel_bit_ready,
        output frame_ready,
        output frame_flat,
        output pixels_loaded
    );

endinterface

// File: rtl/pixel_quantizer.sv
// Combinational pixel-to-fixed-point conversion (binary or grayscale).
// Ports: mode_i (1=gray), bit_i (binary pixel), gray_i (gray code), word_o.
module pixel_quantizer
    import gan_pkg::*;
#(
    parameter int GRAY_BITS = 8,
    parameter int DATA_W    = Q_DATA_W,
    parameter int FRAC_BITS = Q_FRAC_BITS
) (
    input  logic                 mode_i,
    input  logic                 bit_i,
    input  logic [GRAY_BITS-1:0] gray_i,
    output logic [DATA_W-1:0]    word_o
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_BITS;

    logic [DATA_W-1:0] gray_word;

    // Align the gray code's MSB with the integer point: 8-bit 0xFF -> 0x00FF,
    // 4-bit 0xF -> 0x00F0.
    generate
        if (GRAY_BITS >= FRAC_BITS) begin : g_rsh
            localparam int SH = GRAY_BITS - FRAC_BITS;
            assign gray_word = DATA_W'(gray_i >> SH);
        end else begin : g_lsh
            localparam int SH = FRAC_BITS - GRAY_BITS;
            logic [GRAY_BITS+SH-1:0] wide;
            assign wide      = {gray_i, {SH{1'b0}}};
            assign gray_word = DATA_W'(wide);
        end
    endgenerate

    assign word_o = mode_i ? gray_word : (bit_i ? ONE : '0);

endmodule

// File: rtl/pixel_frame_loader.sv
// Serial pixel-bit deserializer building a flattened Q8.8 frame buffer.
// Ports: clk, rst (sync, active-high), bus (slave side of the loader bundle).
module pixel_frame_loader
    import gan_pkg::*;
#(
    parameter int PIXEL_COUNT = gan_pkg::PIXEL_COUNT,
    parameter int GRAY_BITS   = 8,
    parameter int DATA_W      = gan_pkg::Q_DATA_W,
    parameter int FRAC_BITS   = gan_pkg::Q_FRAC_BITS
) (
    input logic                 clk,
    input logic                 rst,
    pixel_frame_loader_if.slave bus
);

    localparam int CNT_W = $clog2(PIXEL_COUNT + 1);
    localparam int BIT_W = (GRAY_BITS > 1) ? $clog2(GRAY_BITS) : 1;

    loader_state_t state_q, state_d;

    logic [CNT_W-1:0]              pix_cnt_q, pix_cnt_d;
    logic [BIT_W-1:0]              bit_cnt_q, bit_cnt_d;
    logic [GRAY_BITS-1:0]          gray_q, gray_d, gray_next;
    logic                          mode_q, mode_d;
    logic [DATA_W*PIXEL_COUNT-1:0] frame_q;
    logic [PIXEL_COUNT-1:0]        wr_en;
    logic [DATA_W-1:0]             word;

    logic ready;
    logic xfer;
    logic first_bit;
    logic cur_mode;
    logic pix_last_bit;
    logic frame_last_pix;
    logic pix_done;
    logic wr_any;

    assign ready     = (state_q == COLLECT) && !rst;
    assign xfer      = bus.pixel_bit_valid && ready;
    assign first_bit = (pix_cnt_q == '0) && (bit_cnt_q == '0);

    // The opening bit of a frame already uses the mode it is about to latch.
    assign cur_mode       = first_bit ? bus.gray_mode : mode_q;
    assign pix_last_bit   = !cur_mode || (bit_cnt_q == BIT_W'(GRAY_BITS - 1));
    assign frame_last_pix = (pix_cnt_q == CNT_W'(PIXEL_COUNT - 1));
    assign pix_done       = xfer && pix_last_bit;
    assign wr_any         = pix_done && !bus.frame_abort;

    generate
        if (GRAY_BITS == 1) begin : g_sh1
            assign gray_next = bus.pixel_bit;
        end else begin : g_shn
            assign gray_next = {gray_q[GRAY_BITS-2:0], bus.pixel_bit};
        end
    endgenerate

    pixel_quantizer #(
        .GRAY_BITS(GRAY_BITS),
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_quant (
        .mode_i(cur_mode),
        .bit_i (bus.pixel_bit),
        .gray_i(gray_next),
        .word_o(word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            pix_cnt_q <= '0;
            bit_cnt_q <= '0;
            gray_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gray_q    <= gray_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gray_d    = gray_q;
        mode_d    = mode_q;
        unique case (state_q)
            COLLECT: begin
                if (bus.frame_abort) begin
                    // Abort beats a coincident transfer, even the last one.
                    pix_cnt_d = '0;
                    bit_cnt_d = '0;
                    gray_d    = '0;
                end else if (xfer) begin
                    if (first_bit) begin
                        mode_d = bus.gray_mode;
                    end
                    if (pix_last_bit) begin
                        bit_cnt_d = '0;
                        gray_d    = '0;
                        if (frame_last_pix) begin
                            pix_cnt_d = '0;
                            state_d   = FULL;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        gray_d    = gray_next;
                    end
                end
            end
            FULL: begin
                if (bus.frame_consume) begin
                    state_d = COLLECT;
                end
            end
        endcase
    end

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < PIXEL_COUNT; i++) begin
            wr_en[i] = wr_any && (pix_cnt_q == CNT_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            for (int i = 0; i < PIXEL_COUNT; i++) begin
                if (wr_en[i]) begin
                    frame_q[i*DATA_W +: DATA_W] <= word;
                end
            end
        end
    end

    assign bus.pixel_bit_ready = ready;
    assign bus.frame_ready     = (state_q == FULL);
    assign bus.frame_flat      = frame_q;
    assign bus.pixels_loaded   = pix_cnt_q;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Scoreboard bench for pixel_frame_loader: 784-pixel/8-bit and 4-pixel/4-bit
// instances driven with directed frames, aborts, backpressure and resets.
module tb_pixel_frame_loader;

    typedef struct {
        int          idx;
        logic [15:0] w;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q4[$];
    logic prev8 = 1'b0;
    logic prev4 = 1'b0;

    pixel_frame_loader_if #(.PIXEL_COUNT(784), .DATA_W(16)) b8 ();
    pixel_frame_loader_if #(.PIXEL_COUNT(4), .DATA_W(16)) b4 ();

    pixel_frame_loader #(
        .PIXEL_COUNT(784), .GRAY_BITS(8), .DATA_W(16), .FRAC_BITS(8)
    ) u8 (
        .clk(clk), .rst(rst), .bus(b8)
    );

    pixel_frame_loader #(
        .PIXEL_COUNT(4), .GRAY_BITS(4), .DATA_W(16), .FRAC_BITS(8)
    ) u4 (
        .clk(clk), .rst(rst), .bus(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input int idx, input logic [15:0] w);
        exp_t e;
        e.idx = idx;
        e.w   = w;
        q8.push_back(e);
    endtask

    task automatic push4(input int idx, input logic [15:0] w);
        exp_t e;
        e.idx = idx;
        e.w   = w;
        q4.push_back(e);
    endtask

    function automatic logic circ(input int i);
        int dr, dc, d;
        dr = i / 28 - 14;
        dc = i % 28 - 14;
        d  = dr * dr + dc * dc;
        return (d >= 36) && (d <= 81);
    endfunction

    function automatic logic [7:0] gv(input int i);
        case (i)
            0: return 8'hFF;
            1: return 8'h80;
            2: return 8'h01;
            default: return 8'((i * 37 + 5) % 256);
        endcase
    endfunction

    // Presents one bit and waits (bounded) until it has transferred.
    task automatic send(input bit sel, input logic b, input logic gm,
                        input logic ab);
        int n;
        n = 0;
        if (sel) begin
            b4.pixel_bit = b; b4.gray_mode = gm;
            b4.frame_abort = ab; b4.pixel_bit_valid = 1'b1;
        end else begin
            b8.pixel_bit = b; b8.gray_mode = gm;
            b8.frame_abort = ab; b8.pixel_bit_valid = 1'b1;
        end
        while (!(sel ? b4.pixel_bit_ready : b8.pixel_bit_ready) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("send_ready_timeout", 32'd0, 32'd1);
        step();
        if (sel) begin
            b4.pixel_bit_valid = 1'b0; b4.frame_abort = 1'b0;
        end else begin
            b8.pixel_bit_valid = 1'b0; b8.frame_abort = 1'b0;
        end
    endtask

    task automatic send4gray(input logic [3:0] v, input logic ab_last);
        for (int k = 3; k >= 0; k--) begin
            send(1'b1, v[k], 1'b1, ab_last && (k == 0));
        end
    endtask

    // Monitor: each completed frame is compared against the queued words.
    always @(negedge clk) begin
        exp_t e;
        if (b8.frame_ready === 1'b1 && prev8 !== 1'b1) begin
            while (q8.size() > 0) begin
                e = q8.pop_front();
                chk($sformatf("frame8_px%0d", e.idx),
                    b8.frame_flat[e.idx*16 +: 16], e.w);
            end
        end
        if (b4.frame_ready === 1'b1 && prev4 !== 1'b1) begin
            while (q4.size() > 0) begin
                e = q4.pop_front();
                chk($sformatf("frame4_px%0d", e.idx),
                    b4.frame_flat[e.idx*16 +: 16], e.w);
            end
        end
        prev8 = b8.frame_ready;
        prev4 = b4.frame_ready;
    end

    initial begin
        logic [7:0] gvv;
        logic       gm;
        rst = 1'b1;
        b8.pixel_bit = 0; b8.pixel_bit_valid = 0; b8.gray_mode = 0;
        b8.frame_abort = 0; b8.frame_consume = 0;
        b4.pixel_bit = 0; b4.pixel_bit_valid = 0; b4.gray_mode = 0;
        b4.frame_abort = 0; b4.frame_consume = 0;
        repeat (3) step();
        chk("rst_ready_low", b8.pixel_bit_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", b8.pixel_bit_ready, 1);
        chk("rst_frame_ready", b8.frame_ready, 0);
        chk("rst_loaded", b8.pixels_loaded, 0);
        chk("rst_w0", b8.frame_flat[15:0], 0);
        chk("rst_w783", b8.frame_flat[783*16 +: 16], 0);
        chk("rst4_ready", b4.pixel_bit_ready, 1);

        // Binary ring pattern, valid held high.
        for (int i = 0; i < 784; i++) begin
            push8(i, circ(i) ? 16'h0100 : 16'h0000);
            if (i == 783) chk("bin_pre_last_fr", b8.frame_ready, 0);
            send(1'b0, circ(i), 1'b0, 1'b0);
        end
        chk("bin_frame_ready", b8.frame_ready, 1);
        chk("bin_loaded_wrap", b8.pixels_loaded, 0);

        // Backpressure while FULL, then consume.
        b8.pixel_bit = 1'b1; b8.gray_mode = 1'b0; b8.pixel_bit_valid = 1'b1;
        repeat (3) begin
            step();
            chk("full_ready", b8.pixel_bit_ready, 0);
            chk("full_loaded", b8.pixels_loaded, 0);
        end
        b8.frame_consume = 1'b1;
        step();
        b8.frame_consume = 1'b0;
        chk("consume_fr", b8.frame_ready, 0);
        chk("consume_ready", b8.pixel_bit_ready, 1);
        step();
        b8.pixel_bit_valid = 1'b0;
        chk("newframe_loaded", b8.pixels_loaded, 1);
        chk("newframe_w0", b8.frame_flat[15:0], 16'h0100);

        // Abort at pixel 100.
        for (int i = 1; i < 100; i++) send(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_abort_loaded", b8.pixels_loaded, 100);
        b8.frame_abort = 1'b1;
        step();
        b8.frame_abort = 1'b0;
        chk("abort_loaded", b8.pixels_loaded, 0);
        chk("abort_keep_w50", b8.frame_flat[50*16 +: 16], 16'h0100);
        chk("abort_keep_w182", b8.frame_flat[182*16 +: 16], 16'h0100);
        chk("abort_fr", b8.frame_ready, 0);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_abort_loaded", b8.pixels_loaded, 1);
        chk("post_abort_w0", b8.frame_flat[15:0], 16'h0000);
        b8.frame_abort = 1'b1;
        step();
        b8.frame_abort = 1'b0;

        // Grayscale frame with idle gaps and gray_mode toggling.
        for (int i = 0; i < 784; i++) begin
            gvv = gv(i);
            push8(i, {8'h00, gvv});
            for (int k = 7; k >= 0; k--) begin
                if ($urandom_range(0, 9) < 3) step();
                gm = (i == 0 && k == 7) ? 1'b1 : 1'($urandom_range(0, 1));
                send(1'b0, gvv[k], gm, 1'b0);
            end
        end
        chk("gray_frame_ready", b8.frame_ready, 1);

        // Abort in FULL is ignored.
        b8.frame_abort = 1'b1;
        step();
        b8.frame_abort = 1'b0;
        chk("full_abort_fr", b8.frame_ready, 1);
        chk("full_abort_w0", b8.frame_flat[15:0], 16'h00FF);
        chk("full_abort_ready", b8.pixel_bit_ready, 0);

        // Reset in FULL.
        rst = 1'b1;
        step();
        chk("rstfull_fr", b8.frame_ready, 0);
        chk("rstfull_loaded", b8.pixels_loaded, 0);
        chk("rstfull_w0", b8.frame_flat[15:0], 0);
        chk("rstfull_w1", b8.frame_flat[31:16], 0);
        chk("rstfull_w783", b8.frame_flat[783*16 +: 16], 0);
        chk("rstfull_ready_low", b8.pixel_bit_ready, 0);
        rst = 1'b0;
        #1;
        chk("rstfull_ready", b8.pixel_bit_ready, 1);

        // 4-bit grayscale instance.
        push4(0, 16'h00F0); push4(1, 16'h0080);
        push4(2, 16'h0010); push4(3, 16'h00A0);
        send4gray(4'hF, 1'b0); send4gray(4'h8, 1'b0);
        send4gray(4'h1, 1'b0); send4gray(4'hA, 1'b0);
        chk("g4_frame_ready", b4.frame_ready, 1);
        b4.frame_consume = 1'b1;
        step();
        b4.frame_consume = 1'b0;
        chk("g4_consume_ready", b4.pixel_bit_ready, 1);

        // Abort coincident with the final bit.
        send4gray(4'h3, 1'b0); send4gray(4'h5, 1'b0);
        send4gray(4'h7, 1'b0); send4gray(4'hC, 1'b1);
        chk("abort_last_fr", b4.frame_ready, 0);
        chk("abort_last_loaded", b4.pixels_loaded, 0);
        chk("abort_last_w3", b4.frame_flat[63:48], 16'h00A0);
        chk("abort_last_w0", b4.frame_flat[15:0], 16'h0030);

        // Consume in COLLECT has no effect.
        b4.frame_consume = 1'b1;
        step();
        b4.frame_consume = 1'b0;
        chk("collect_consume_fr", b4.frame_ready, 0);
        chk("collect_consume_ready", b4.pixel_bit_ready, 1);
        chk("collect_consume_loaded", b4.pixels_loaded, 0);

        // Binary frame on the small instance.
        push4(0, 16'h0100); push4(1, 16'h0000);
        push4(2, 16'h0100); push4(3, 16'h0100);
        send(1'b1, 1'b1, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0); send(1'b1, 1'b1, 1'b0, 1'b0);
        chk("b4_frame_ready", b4.frame_ready, 1);
        b4.frame_consume = 1'b1;
        step();
        b4.frame_consume = 1'b0;

        // Reset mid-frame.
        send4gray(4'h5, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b0);
        chk("mid_loaded", b4.pixels_loaded, 1);
        rst = 1'b1;
        step();
        chk("rstmid_fr", b4.frame_ready, 0);
        chk("rstmid_loaded", b4.pixels_loaded, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rstmid_w%0d", i), b4.frame_flat[i*16 +: 16], 0);
        end
        rst = 1'b0;
        #1;
        chk("rstmid_ready", b4.pixel_bit_ready, 1);

        step();
        chk("q8_empty", q8.size(), 0);
        chk("q4_empty", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
